// File: rtl/datapath_seq_pkg.sv
// Shared types for the sequential register-file datapath: ALU opcodes and FSM states.
package datapath_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_ADC   = 3'b001,
        OP_SUB   = 3'b010,
        OP_AND   = 3'b011,
        OP_OR    = 3'b100,
        OP_XOR   = 3'b101,
        OP_NOT   = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/datapath_seq_alu.sv
// Combinational ALU: result and carry for the eight datapath opcodes.
import datapath_seq_pkg::*;

module datapath_seq_alu #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_res_c,
    output logic             o_carry_c
);

    logic [WIDTH:0] w_sum;

    // Arithmetic is done one bit wider so the top bit is the carry; SUB carry means "no borrow".
    always_comb begin
        w_sum     = '0;
        o_res_c   = '0;
        o_carry_c = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum     = {1'b0, i_a} + {1'b0, i_b};
                o_res_c   = w_sum[WIDTH-1:0];
                o_carry_c = w_sum[WIDTH];
            end
            OP_ADC: begin
                w_sum     = {1'b0, i_a} + {1'b0, i_b} + (WIDTH+1)'(i_cin);
                o_res_c   = w_sum[WIDTH-1:0];
                o_carry_c = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sum     = {1'b0, i_a} - {1'b0, i_b};
                o_res_c   = w_sum[WIDTH-1:0];
                o_carry_c = ~w_sum[WIDTH];
            end
            OP_AND:   o_res_c = i_a & i_b;
            OP_OR:    o_res_c = i_a | i_b;
            OP_XOR:   o_res_c = i_a ^ i_b;
            OP_NOT:   o_res_c = ~i_a;
            OP_PASSB: o_res_c = i_b;
            default:  o_res_c = '0;
        endcase
    end

endmodule

// File: rtl/datapath_seq.sv
// Multi-cycle register-file datapath: IDLE -> RD_A -> RD_B -> EXEC -> WB, immediates go IDLE -> WB.
// Optional DATAPATH_SEQ_CARRY_FLAG_EN keeps an internal carry flag that feeds ADC instead of carry_in.
import datapath_seq_pkg::*;

module datapath_seq #(
    parameter  int unsigned WIDTH  = 4,
    parameter  int unsigned NREGS  = 4,
    localparam int unsigned ADDR_W = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_imm,
    input  logic [2:0]        operacao,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  dados,
    input  logic              carry_in,
    output logic [WIDTH-1:0]  resultado,
    output logic              carry_out,
    output logic              done,
    output logic              busy
);

    state_e             r_state;
    logic               r_in_ready;
    logic               r_done;
    logic               r_imm;
    op_e                r_op;
    logic [ADDR_W-1:0]  r_rs1;
    logic [ADDR_W-1:0]  r_rs2;
    logic [ADDR_W-1:0]  r_rd;
    logic [WIDTH-1:0]   r_dados;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic [WIDTH-1:0]   r_resultado;
    logic [WIDTH-1:0]   r_rf [NREGS];

    logic [WIDTH-1:0]   w_rf_a;
    logic [WIDTH-1:0]   w_rf_b;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_carry;
    logic               w_cin;

    // Out-of-range addresses (non-power-of-two depth) read as zero.
    assign w_rf_a = (32'(r_rs1) < NREGS) ? r_rf[r_rs1] : '0;
    assign w_rf_b = (32'(r_rs2) < NREGS) ? r_rf[r_rs2] : '0;

`ifdef DATAPATH_SEQ_CARRY_FLAG_EN
    logic r_cflag;
    logic w_unused_cin;

    assign w_unused_cin = carry_in;
    assign w_cin        = r_cflag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cflag <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_cflag <= w_alu_carry;
        end
    end
`else
    assign w_cin = carry_in;
`endif

    datapath_seq_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a       (r_a),
        .i_b       (r_b),
        .i_op      (r_op),
        .i_cin     (w_cin),
        .o_res_c   (w_alu_res),
        .o_carry_c (w_alu_carry)
    );

    // Sequencer; done and resultado are set on the edge entering WB so they are visible during WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_done      <= 1'b0;
            r_imm       <= 1'b0;
            r_op        <= OP_ADD;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_dados     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_resultado <= '0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_imm      <= in_imm;
                        r_op       <= op_e'(operacao);
                        r_rs1      <= rs1;
                        r_rs2      <= rs2;
                        r_rd       <= rd;
                        r_dados    <= dados;
                        r_in_ready <= 1'b0;
                        if (in_imm) begin
                            r_resultado <= dados;
                            r_done      <= 1'b1;
                            r_state     <= S_WB;
                        end else begin
                            r_state <= S_RD_A;
                        end
                    end
                end
                S_RD_A: begin
                    r_a     <= w_rf_a;
                    r_state <= S_RD_B;
                end
                S_RD_B: begin
                    r_b     <= w_rf_b;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_result    <= w_alu_res;
                    r_carry     <= w_alu_carry;
                    r_resultado <= w_alu_res;
                    r_done      <= 1'b1;
                    r_state     <= S_WB;
                end
                S_WB: begin
                    if (32'(r_rd) < NREGS) begin
                        r_rf[r_rd] <= r_imm ? r_dados : r_result;
                    end
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = ~r_in_ready;
    assign done      = r_done;
    assign resultado = r_resultado;
    assign carry_out = r_carry;

endmodule
